// File: rtl/seven_seg_pkg.sv
// Shared constants and the hex-to-segment decode for the seven-segment
// display driver. Segment codes are active-low {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    localparam int MAX_DIGITS = 8;

    // All segments dark in active-low form.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low glyphs for 0-9, A, b, C, d, E, F.
    localparam logic [6:0] HEX_CODES [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_CODES[nibble];
    endfunction

endpackage

// File: rtl/seven_seg_scan_timer.sv
// Slot timer for the multiplexed display: counts cycles within a digit slot,
// steps the digit index, flags the anti-ghosting guard window and pulses
// frame_done when the scan returns to digit 0.
module seven_seg_scan_timer #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 2,
    parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [IDX_W-1:0] idx,
    output logic             guard,
    output logic             wrap,
    output logic             frame_done
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt;
    logic             slot_end;

    assign slot_end = (cnt == CNT_LAST);
    // wrap is the edge on which the scan returns to digit 0.
    assign wrap     = slot_end && (idx == IDX_LAST);

    generate
        if (GUARD_CYCLES == 0) begin : g_no_guard
            assign guard = 1'b0;
        end else begin : g_guard
            assign guard = (cnt < CNT_W'(GUARD_CYCLES));
        end
    endgenerate

    // Slot counter, digit index and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed N-digit common-anode hex display driver with per-digit
// decimal point and blanking, guard interval between slots, and tear-free
// value update at frame boundaries.
// Optional build macro SEVEN_SEG_LEADING_ZERO_BLANK_EN: blank digits above
// the most significant nonzero nibble (digit 0 always shown).
module seven_segment_mux
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD_CYCLES   = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // XOR masks turn the internal active-low form into the pin polarity.
    localparam logic [6:0]            SEG_MASK = (SEG_ACTIVE_LOW != 0) ? 7'h00 : 7'h7F;
    localparam logic                  DP_MASK  = (SEG_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [NUM_DIGITS-1:0] AN_MASK  = (AN_ACTIVE_LOW != 0) ? '0 : '1;

    logic [IDX_W-1:0] idx;
    logic             guard;
    logic             wrap;

    seven_seg_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .GUARD_CYCLES (GUARD_CYCLES),
        .IDX_W        (IDX_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .idx        (idx),
        .guard      (guard),
        .wrap       (wrap),
        .frame_done (frame_done)
    );

    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic                    pend_valid;
    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_blank;

    // Pending/shadow double buffer: the shadow only changes on the frame wrap
    // so a frame never mixes old and new digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value   <= '0;
            pend_dp      <= '0;
            pend_blank   <= '0;
            pend_valid   <= 1'b0;
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_blank <= '0;
        end else if (wrap) begin
            pend_valid <= 1'b0;
            if (load) begin
                shadow_value <= value;
                shadow_dp    <= dp_in;
                shadow_blank <= blank_in;
            end else if (pend_valid) begin
                shadow_value <= pend_value;
                shadow_dp    <= pend_dp;
                shadow_blank <= pend_blank;
            end
        end else if (load) begin
            pend_value <= value;
            pend_dp    <= dp_in;
            pend_blank <= blank_in;
            pend_valid <= 1'b1;
        end
    end

    logic [3:0]            nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] an_hot;
    logic [NUM_DIGITS-1:0] auto_blank;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib[gi]    = shadow_value[4*gi +: 4];
            assign an_hot[gi] = (idx == IDX_W'(gi));
        end
    endgenerate

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] zero_from;

    // A digit is auto-blanked when it and every digit above it are zero.
    always_comb begin
        zero_from = '0;
        zero_from[NUM_DIGITS-1] = (nib[NUM_DIGITS-1] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] & (nib[i] == 4'h0);
        end
        auto_blank    = zero_from;
        auto_blank[0] = 1'b0;
    end
`else
    assign auto_blank = '0;
`endif

    logic [6:0]            seg_low;
    logic                  dp_low;
    logic [NUM_DIGITS-1:0] an_low;

    // Active-low decode of the currently scanned digit.
    always_comb begin
        seg_low = SEG_OFF;
        if (!(shadow_blank[idx] || auto_blank[idx])) begin
            seg_low = hex_to_seg(nib[idx]);
        end
        dp_low = ~(shadow_dp[idx] & ~shadow_blank[idx]);
        an_low = ~an_hot;
    end

    // Output register: polarity applied here; everything dark during guard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF ^ SEG_MASK;
            dp  <= 1'b1 ^ DP_MASK;
            an  <= '1 ^ AN_MASK;
        end else if (guard) begin
            seg <= SEG_OFF ^ SEG_MASK;
            dp  <= 1'b1 ^ DP_MASK;
            an  <= '1 ^ AN_MASK;
        end else begin
            seg <= seg_low ^ SEG_MASK;
            dp  <= dp_low ^ DP_MASK;
            an  <= an_low ^ AN_MASK;
        end
    end

endmodule

// File: tb/tb_seven_segment_mux.sv
// Self-checking bench for seven_segment_mux (4 digits, 8-cycle slots,
// 2 guard cycles). Also valid with SEVEN_SEG_LEADING_ZERO_BLANK_EN defined.
module tb_seven_segment_mux;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int GC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   value = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    blank_in = '0;
    logic          load = 1'b0;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    seven_segment_mux #(
        .NUM_DIGITS     (ND),
        .REFRESH_DIV    (RD),
        .GUARD_CYCLES   (GC),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .load       (load),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: elapsed cycles since reset release plus the
    // displayed and queued contents.
    int         k;
    logic [15:0] m_val, p_val;
    logic [3:0]  m_dp, p_dp, m_bl, p_bl;
    logic        p_valid;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_an;
    logic        exp_fd;
    int          t_pos, t_dig;
    logic        t_wrap;
    logic [6:0]  cap_seg [ND];
    logic        cap_dp  [ND];
    logic [3:0]  cap_an  [ND];
    logic [6:0]  pre_seg [ND];

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic model_reset();
        k = 0;
        m_val = '0; m_dp = '0; m_bl = '0;
        p_val = '0; p_dp = '0; p_bl = '0;
        p_valid = 1'b0;
    endtask

    // One clock: predict the outputs visible after this edge, apply the
    // load rules to the model, then advance to just after the edge.
    task automatic tick();
        logic [15:0] upper;
        logic        blk;
        t_pos  = k % RD;
        t_dig  = (k / RD) % ND;
        t_wrap = (t_pos == RD - 1) && (t_dig == ND - 1);
        if (t_pos < GC) begin
            exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF;
        end else begin
            upper = m_val >> (4 * t_dig);
            blk   = m_bl[t_dig];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
            if (t_dig > 0 && upper == 16'h0) blk = 1'b1;
`endif
            exp_seg = blk ? 7'h7F : glyph(upper[3:0]);
            exp_dp  = !(m_dp[t_dig] && !m_bl[t_dig]);
            exp_an  = ~(4'b0001 << t_dig);
        end
        exp_fd = t_wrap;
        if (t_wrap) begin
            if (load) begin
                m_val = value; m_dp = dp_in; m_bl = blank_in;
            end else if (p_valid) begin
                m_val = p_val; m_dp = p_dp; m_bl = p_bl;
            end
            p_valid = 1'b0;
        end else if (load) begin
            p_val = value; p_dp = dp_in; p_bl = blank_in;
            p_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        k++;
    endtask

    // Run to the next frame wrap (capturing pos-4 seg before it), then
    // capture each digit's outputs at slot position 4 for one full frame.
    task automatic run_capture();
        int n;
        n = 0;
        for (int d = 0; d < ND; d++) pre_seg[d] = 7'h55;
        t_wrap = 1'b0;
        while (!t_wrap && n < 200) begin
            tick();
            if (t_pos == 4) pre_seg[t_dig] = seg;
            n++;
        end
        for (int c = 0; c < ND * RD; c++) begin
            tick();
            if (t_pos == 4) begin
                cap_seg[t_dig] = seg;
                cap_dp[t_dig]  = dp;
                cap_an[t_dig]  = an;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({seg, dp, an, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_hold got seg=%h dp=%b an=%h fd=%b want 7f 1 f 0", seg, dp, an, frame_done);
        end
        rst_n = 1'b1;
        model_reset();
        #1;
        for (int c = 0; c < 11; c++) begin
            logic [3:0] want_an;
            if (c >= 2) tick();
            else if (c == 1) tick();
            want_an = (c < 3) ? 4'hF : (c < 9) ? 4'hE : (c < 11) ? 4'hF : 4'hD;
            n_cmp++;
            if (an !== want_an || frame_done !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_scan c=%0d got an=%h fd=%b want an=%h fd=0", c, an, frame_done, want_an);
            end
            if (c < 3) begin
                n_cmp++;
                if (seg !== 7'h7F) begin
                    n_bad++;
                    $display("FAIL reset_seg c=%0d got %h want 7f", c, seg);
                end
            end
        end
        tick();
        n_cmp++;
        if (an !== 4'hD || seg !== 7'h40) begin
            n_bad++;
            $display("FAIL reset_slot1 got an=%h seg=%h want d 40", an, seg);
        end
        $display("test_reset done k=%0d", k);
    endtask

    task automatic test_load();
        value = 16'h12AF; dp_in = '0; blank_in = '0; load = 1'b1;
        tick();
        load = 1'b0;
        run_capture();
        n_cmp++;
        if (pre_seg[3] !== 7'h40) begin
            n_bad++;
            $display("FAIL load_before_wrap got %h want 40", pre_seg[3]);
        end
        for (int d = 0; d < ND; d++) begin
            logic [6:0] want;
            want = (d == 0) ? 7'h0E : (d == 1) ? 7'h08 : (d == 2) ? 7'h24 : 7'h79;
            n_cmp++;
            if (cap_seg[d] !== want || cap_an[d] !== ~(4'b0001 << d)) begin
                n_bad++;
                $display("FAIL load_digit%0d got seg=%h an=%h want seg=%h", d, cap_seg[d], cap_an[d], want);
            end
        end
        $display("test_load done 12AF");
    endtask

    task automatic test_back_to_back();
        value = 16'h1111; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (3) tick();
        value = 16'h2222; load = 1'b1;
        tick();
        load = 1'b0;
        value = 16'h3456;
        run_capture();
        for (int d = 0; d < ND; d++) begin
            n_cmp++;
            if (cap_seg[d] !== 7'h24) begin
                n_bad++;
                $display("FAIL last_wins digit%0d got %h want 24", d, cap_seg[d]);
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_wrap_load();
        int n;
        n = 0;
        while (!((k % RD) == RD - 1 && ((k / RD) % ND) == ND - 1) && n < 200) begin
            tick();
            n++;
        end
        value = 16'h3333; load = 1'b1;
        tick();
        load = 1'b0;
        n_cmp++;
        if (frame_done !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_fd got %b want 1", frame_done);
        end
        repeat (RD / 2) tick();
        n_cmp++;
        if (seg !== 7'h30 || an !== 4'hE) begin
            n_bad++;
            $display("FAIL wrap_load got seg=%h an=%h want 30 e", seg, an);
        end
        n_cmp++;
        if (frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL fd_width got %b want 0", frame_done);
        end
        $display("test_wrap_load done");
    endtask

    task automatic test_blank_dp();
        value = 16'h8888; dp_in = 4'b0101; blank_in = 4'b0100; load = 1'b1;
        tick();
        load = 1'b0;
        run_capture();
        n_cmp++;
        if ({cap_seg[2], cap_dp[2], cap_an[2]} !== {7'h7F, 1'b1, 4'hB}) begin
            n_bad++;
            $display("FAIL blank_digit2 got seg=%h dp=%b an=%h want 7f 1 b", cap_seg[2], cap_dp[2], cap_an[2]);
        end
        n_cmp++;
        if ({cap_seg[0], cap_dp[0]} !== {7'h00, 1'b0}) begin
            n_bad++;
            $display("FAIL dp_digit0 got seg=%h dp=%b want 00 0", cap_seg[0], cap_dp[0]);
        end
        n_cmp++;
        if ({cap_seg[1], cap_dp[1]} !== {7'h00, 1'b1}) begin
            n_bad++;
            $display("FAIL dp_digit1 got seg=%h dp=%b want 00 1", cap_seg[1], cap_dp[1]);
        end
        dp_in = '0; blank_in = '0;
        $display("test_blank_dp done");
    endtask

    task automatic test_reset_mid();
        int n;
        value = 16'h9876; load = 1'b1;
        tick();
        load = 1'b0;
        run_capture();
        n = 0;
        while (!((k % RD) == 4 && ((k / RD) % ND) == 2) && n < 200) begin
            tick();
            n++;
        end
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({seg, dp, an, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset got seg=%h dp=%b an=%h fd=%b want 7f 1 f 0", seg, dp, an, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < ND * RD + 4; c++) begin
            tick();
            n_cmp++;
            if ({seg, dp, an, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
                n_bad++;
                $display("FAIL after_reset k=%0d got seg=%h dp=%b an=%h fd=%b want seg=%h dp=%b an=%h fd=%b",
                         k, seg, dp, an, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
            end
            if (c == 4) begin
                n_cmp++;
                if (seg !== 7'h40 || an !== 4'hE) begin
                    n_bad++;
                    $display("FAIL restart_digit0 got seg=%h an=%h want 40 e", seg, an);
                end
            end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_lzb();
        logic [6:0] want_hi;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        want_hi = 7'h7F;
`else
        want_hi = 7'h40;
`endif
        value = 16'h0050; dp_in = '0; blank_in = '0; load = 1'b1;
        tick();
        load = 1'b0;
        run_capture();
        n_cmp++;
        if ({cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0]} !== {want_hi, want_hi, 7'h12, 7'h40}) begin
            n_bad++;
            $display("FAIL lzb got %h %h %h %h want %h %h 12 40",
                     cap_seg[3], cap_seg[2], cap_seg[1], cap_seg[0], want_hi, want_hi);
        end
        $display("test_lzb done");
    endtask

    task automatic test_random();
        for (int c = 0; c < 640; c++) begin
            value    = 16'($urandom);
            dp_in    = 4'($urandom);
            blank_in = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
            if ($urandom_range(0, 5) == 0) value = value & 16'h00F0;
            load     = ($urandom_range(0, 5) == 0);
            tick();
            n_cmp++;
            if ({seg, dp, an, frame_done} !== {exp_seg, exp_dp, exp_an, exp_fd}) begin
                n_bad++;
                $display("FAIL random k=%0d got seg=%h dp=%b an=%h fd=%b want seg=%h dp=%b an=%h fd=%b",
                         k, seg, dp, an, frame_done, exp_seg, exp_dp, exp_an, exp_fd);
            end
        end
        load = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load();
        test_back_to_back();
        test_wrap_load();
        test_blank_dp();
        test_reset_mid();
        test_lzb();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
